// File: rtl/data_memory_ctrl.sv
// Data memory with req/done handshake, wait states, byte lanes and sub-word loads.
// Optional MEM_MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of force-aligning.
module data_memory_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    input  logic              MemtoReg,
    output logic              busy,
    output logic              done,
    output logic [31:0]       read_data,
    output logic              misalign
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LA_W  = IDX_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [LA_W-1:0]   addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       load_q, load_d;
    logic              mis_q, mis_d;

    logic [31:0]       mem_q [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [31:0]       word;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       rd_ext;
    logic [31:0]       wr_word;
    logic [3:0]        be;
    logic              trap;
    logic              access;

    assign idx    = addr_q[LA_W-1:2];
    assign lane   = addr_q[1:0];
    assign word   = mem_q[idx];
    assign byte_v = 8'(word >> {lane, 3'b000});
    assign half_v = lane[1] ? word[31:16] : word[15:0];
    assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = ((size_q == 2'b01) && lane[0]) ||
                  (size_q[1] && (lane != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Sub-word stores replicate the data across lanes; byte enables pick the target.
    always_comb begin
        be      = 4'b1111;
        wr_word = wdata_q;
        rd_ext  = word;
        unique case (size_q)
            2'b00: begin
                be      = 4'b0001 << lane;
                wr_word = {4{wdata_q[7:0]}};
                rd_ext  = uns_q ? {24'd0, byte_v}
                                : {{24{byte_v[7]}}, byte_v};
            end
            2'b01: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
                rd_ext  = uns_q ? {16'd0, half_v}
                                : {{16{half_v[15]}}, half_v};
            end
            default: begin
                be      = 4'b1111;
                wr_word = wdata_q;
                rd_ext  = word;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        mis_d   = mis_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    uns_d   = unsigned_ld;
                    addr_d  = address[LA_W-1:0];
                    wdata_d = write_data;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    mis_d   = trap;
                    if (trap) begin
                        load_d = '0;
                    end else if (!we_q) begin
                        load_d = rd_ext;
                    end
                end
            end
            S_RESP: begin
                busy    = 1'b1;
                done    = 1'b1;
                mis_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            mis_q   <= mis_d;
        end
    end

    // Reset clears the whole array so an aborted store leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (access && we_q && !trap) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    assign read_data = MemtoReg ? load_q : 32'(address);
    assign misalign  = mis_q;

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised successor to the single-cycle MIPS data memory. It adds:
- a clocked request/done handshake with configurable wait states;
- byte/half/word stores through byte lanes;
- sign- or zero-extended sub-word loads.

It sits between the ALU result and the register-file writeback mux. It keeps the MemtoReg output selection between load data and the ALU address.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, 4..4096
WAIT_CYCLES, 1, extra cycles before the array access; 0..15
ADDR_W, 32, width of the address port

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  access request; sampled only in IDLE
we  in  1  1 = store, 0 = load; latched with req
size  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
unsigned_ld  in  1  1 = zero-extend sub-word load, 0 = sign-extend
address  in  ADDR_W  byte address / ALU result
write_data  in  32  store data; low-order bytes are used for byte/half stores
MemtoReg  in  1  output select: 1 = load data, 0 = address
busy  out  1  high while an accepted access is in flight
done  out  1  one-cycle pulse when the access completes
read_data  out  32  MemtoReg ? load_q : address (combinational mux)
misalign  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset (asynchronous) forces:
  - FSM to IDLE;
  - busy=0, done=0, misalign=0;
  - load_q=0 and every memory word to 0.
  A reset mid-operation aborts the access. A pending store is discarded and the array is cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req=1, latch address, we, size, unsigned_ld and write_data.
  - Load counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - busy=1.
  - If counter!=0, decrement.
  - If counter==0, perform the array access on this edge and go to RESP.
- RESP:
  - busy=1, done=1 for exactly one cycle, then IDLE.
- Latency: req accepted at edge N gives done high in the cycle after edge N+WAIT_CYCLES+1. Throughput is one access per WAIT_CYCLES+3 cycles.
- req while busy is ignored; there is no queueing. A req held high in RESP is not seen until IDLE.
- Word index = latched address[log2(DEPTH)+1:2]. Upper address bits are ignored, so accesses alias/wrap modulo DEPTH*4 bytes.
- Lane = address[1:0], little-endian.
- Stores:
  - byte writes write_data[7:0] to the lane;
  - half writes write_data[15:0] to lanes {addr[1],0}/+1;
  - word writes all 4 lanes.
  - Unwritten lanes keep their value. load_q is not updated on stores.
- Loads: select the byte/half/word from the addressed word and extend to 32 bits per unsigned_ld (ignored for word loads). The result is registered into load_q at the access edge. load_q holds until the next load completes.
- read_data with MemtoReg=0 follows the live address input, not the latched one.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - A half access with address[0]=1, or a word access with address[1:0]!=0, is misaligned.
  - The array is not written and load_q is set to 0.
  - misalign=1 in the RESP cycle only, coincident with done. The handshake timing is unchanged.
- Undefined:
  - Misaligned addresses are force-aligned: the half ignores bit 0, the word ignores bits 1:0.
  - misalign is tied to 0.

Test Plan:
- WAIT_CYCLES=2: sw 0xDEADBEEF @0x10 with req at edge 0 -> busy=1 from cycle 1, done pulse in cycle 4 only; then lw @0x10 with MemtoReg=1 -> read_data=0xDEADBEEF.
- After the above: lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x10 -> 0xFFFFBEEF; lhu @0x12 -> 0x0000DEAD.
- sb write_data=0x00000055 @0x11, then lw @0x10 -> 0xDEAD55EF (other lanes intact).
- DEPTH=256: sw 0x12345678 @0x400, then lw @0x000 -> 0x12345678 (wrap). req pulsed while busy -> ignored, no extra done.
- Start sw 0xFFFFFFFF @0x20, assert rst during WAIT -> busy=0, done=0 immediately; after release, lw @0x20 -> 0x00000000.
- lw @0x12 after sw 0xCAFEF00D @0x10 -> with MEM_MISALIGN_TRAP_EN: misalign=1 with done, read_data=0; without: read_data=0xCAFEF00D, misalign=0. MemtoReg=0 -> read_data=address.
